// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb
//   Integer register file for the dual-issue pipeline with an integrated
//   pending-write scoreboard. x0 is hard-wired to zero.
//
// Parameters
//   XLEN    data width of each register / data port
//   NUM_RD  number of combinational read ports
//   BYPASS  1 = same-cycle write data forwarded to reads and used to suppress
//           hazards; 0 = reads return the stored value only
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   rd0_*, rd1_*          two write-back ports (index, enable, data);
//                         port 1 is the younger instruction and wins ties
//   ra_i / ra_value_o     packed read indices / packed read data
//   ra_hazard_o           per read port: source has an unresolved producer
//   issue_valid_i/rd_i    marks a destination as pending
//   flush_i               discards every pending mark
//   busy_o                scoreboard state, bit 0 always 0
module riscv_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [4:0]             rd0_i,
  input  logic                   rd0_we_i,
  input  logic [XLEN-1:0]        rd0_value_i,
  input  logic [4:0]             rd1_i,
  input  logic                   rd1_we_i,
  input  logic [XLEN-1:0]        rd1_value_i,
  input  logic [5*NUM_RD-1:0]    ra_i,
  output logic [XLEN*NUM_RD-1:0] ra_value_o,
  output logic [NUM_RD-1:0]      ra_hazard_o,
  input  logic                   issue_valid_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   flush_i,
  output logic [31:0]            busy_o
);

  // A write port is effective only when enabled and not targeting x0.
  logic we0, we1;
  assign we0 = rd0_we_i && (rd0_i != 5'd0);
  assign we1 = rd1_we_i && (rd1_i != 5'd0);

  // Flat view of the architectural state, entry 0 tied to zero.
  logic [XLEN-1:0] rf_view [32];
  assign rf_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_reg
      localparam logic [4:0] IDX = 5'(gi);
      logic [XLEN-1:0] q;
      // Port 1 checked first: it is the younger producer.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          q <= '0;
        end else if (we1 && (rd1_i == IDX)) begin
          q <= rd1_value_i;
        end else if (we0 && (rd0_i == IDX)) begin
          q <= rd0_value_i;
        end
      end
      assign rf_view[gi] = q;
    end
  endgenerate

  // Scoreboard: flush > issue set > write-back clear.
  logic [31:1] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_valid_i && (issue_rd_i == 5'(i))) begin
          busy_d[i] = 1'b1;
        end else if ((we0 && (rd0_i == 5'(i))) || (we1 && (rd1_i == 5'(i)))) begin
          busy_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  logic [31:0] busy_view;
  assign busy_view = {busy_q, 1'b0};
  assign busy_o    = busy_view;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [4:0]      ra;
      logic            hit0, hit1;
      logic [XLEN-1:0] val;

      assign ra   = ra_i[5*gi +: 5];
      // we0/we1 already exclude x0, so a hit implies ra != 0.
      assign hit0 = (BYPASS != 0) && we0 && (rd0_i == ra);
      assign hit1 = (BYPASS != 0) && we1 && (rd1_i == ra);

      // Outputs forced to zero while in reset so bypassed data cannot leak.
      always_comb begin
        val = '0;
        if (!rst_i && (ra != 5'd0)) begin
          if (hit1) begin
            val = rd1_value_i;
          end else if (hit0) begin
            val = rd0_value_i;
          end else begin
            val = rf_view[ra];
          end
        end
      end

      assign ra_value_o[XLEN*gi +: XLEN] = val;
      assign ra_hazard_o[gi] = !rst_i && busy_view[ra] && !(hit0 || hit1);
    end
  endgenerate

endmodule

// File: tb/tb_riscv_regfile_sb.sv
module tb_riscv_regfile_sb;
  localparam int XL = 64;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [4:0]    rd0, rd1, ird;
  logic          we0, we1, iv, flush;
  logic [XL-1:0] v0, v1;
  logic [5*NR-1:0] ra;

  logic [XL*NR-1:0] val_b, val_n;
  logic [NR-1:0]    hz_b, hz_n;
  logic [31:0]      busy_b, busy_n;

  riscv_regfile_sb #(.XLEN(XL), .NUM_RD(NR), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .rd0_i(rd0), .rd0_we_i(we0), .rd0_value_i(v0),
    .rd1_i(rd1), .rd1_we_i(we1), .rd1_value_i(v1),
    .ra_i(ra), .ra_value_o(val_b), .ra_hazard_o(hz_b),
    .issue_valid_i(iv), .issue_rd_i(ird), .flush_i(flush), .busy_o(busy_b));

  riscv_regfile_sb #(.XLEN(XL), .NUM_RD(NR), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst),
    .rd0_i(rd0), .rd0_we_i(we0), .rd0_value_i(v0),
    .rd1_i(rd1), .rd1_we_i(we1), .rd1_value_i(v1),
    .ra_i(ra), .ra_value_o(val_n), .ra_hazard_o(hz_n),
    .issue_valid_i(iv), .issue_rd_i(ird), .flush_i(flush), .busy_o(busy_n));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: architectural registers and the set of pending producers.
  logic [XL-1:0] m_regs [32];
  logic [31:0]   m_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [XL-1:0] m_read(input logic [4:0] a, input bit byp);
    if (rst || a == 0) return '0;
    if (byp && we1 && rd1 == a) return v1;
    if (byp && we0 && rd0 == a) return v0;
    return m_regs[a];
  endfunction

  function automatic logic m_hz(input logic [4:0] a, input bit byp);
    if (rst || a == 0) return 1'b0;
    if (byp && ((we0 && rd0 == a) || (we1 && rd1 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  // Apply the effect of one clock edge to the model.
  task automatic m_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (we0 && rd0 != 0) m_regs[rd0] = v0;
      if (we1 && rd1 != 0) m_regs[rd1] = v1;   // younger write lands last
      if (flush) m_busy = '0;
      else begin
        if (we0) m_busy[rd0] = 1'b0;
        if (we1) m_busy[rd1] = 1'b0;
        if (iv)  m_busy[ird] = 1'b1;           // new producer supersedes
        m_busy[0] = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < NR; k++) begin
      chk($sformatf("rnd val_b p%0d", k), val_b[XL*k +: XL], m_read(ra[5*k +: 5], 1'b1));
      chk($sformatf("rnd val_n p%0d", k), val_n[XL*k +: XL], m_read(ra[5*k +: 5], 1'b0));
      chk($sformatf("rnd hz_b p%0d", k), 64'(hz_b[k]), 64'(m_hz(ra[5*k +: 5], 1'b1)));
      chk($sformatf("rnd hz_n p%0d", k), 64'(hz_n[k]), 64'(m_hz(ra[5*k +: 5], 1'b0)));
    end
    chk("rnd busy_b", 64'(busy_b), rst ? 64'd0 : 64'(m_busy));
    chk("rnd busy_n", 64'(busy_n), rst ? 64'd0 : 64'(m_busy));
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iv = 0; flush = 0;
    rd0 = 0; rd1 = 0; ird = 0; v0 = '0; v1 = '0;
  endtask

  // Entered at posedge+1 with inputs set; leaves at the next posedge+1.
  task automatic run_cycle();
    #2;
    check_model();
    @(posedge clk);
    m_update();
    #1;
  endtask

  typedef struct {
    logic [4:0]  rd0;  logic we0; logic [63:0] v0;
    logic [4:0]  rd1;  logic we1; logic [63:0] v1;
    logic        iv;   logic [4:0] ird; logic fl;
    logic [4:0]  ra;
    logic [63:0] eb, en;      // expected read data, bypass / no bypass
    logic        hb, hn;      // expected hazards
    logic [31:0] busy;        // expected busy_o after the edge
  } vec_t;

  function automatic vec_t mk(input logic [4:0] r0, input logic w0, input logic [63:0] d0,
                              input logic [4:0] r1, input logic w1, input logic [63:0] d1,
                              input logic i_v, input logic [4:0] i_rd, input logic fl,
                              input logic [4:0] a, input logic [63:0] eb, input logic [63:0] en,
                              input logic hb, input logic hn, input logic [31:0] bz);
    vec_t t;
    t.rd0 = r0; t.we0 = w0; t.v0 = d0; t.rd1 = r1; t.we1 = w1; t.v1 = d1;
    t.iv = i_v; t.ird = i_rd; t.fl = fl; t.ra = a;
    t.eb = eb; t.en = en; t.hb = hb; t.hn = hn; t.busy = bz;
    return t;
  endfunction

  localparam logic [63:0] BIG = 64'hFFFF_0000_FFFF_0000;
  vec_t tbl [17];

  initial begin
    tbl[0]  = mk(7, 1, 64'h11111111, 7, 1, 64'h22222222, 0, 0, 0, 7, 64'h22222222, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 64'h22222222, 64'h22222222, 0, 0, 0);
    tbl[2]  = mk(7, 1, 64'h11111111, 7, 0, 64'h33, 0, 0, 0, 7, 64'h11111111, 64'h22222222, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 64'h11111111, 64'h11111111, 0, 0, 0);
    tbl[4]  = mk(0, 1, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 3, 1, 64'hA5A5A5A5, 0, 0, 0, 3, 64'hA5A5A5A5, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 64'hA5A5A5A5, 64'hA5A5A5A5, 0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 0, 32'h200);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 1, 32'h200);
    tbl[9]  = mk(9, 1, 64'h99, 0, 0, 0, 0, 0, 0, 9, 64'h99, 0, 0, 1, 0);
    tbl[10] = mk(12, 1, 64'hC, 0, 0, 0, 1, 12, 0, 12, 64'hC, 0, 0, 0, 32'h1000);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 12, 64'hC, 64'hC, 1, 1, 32'h1010);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 20, 0, 4, 0, 0, 1, 1, 32'h0010_1010);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 6, 1, 20, 0, 0, 1, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
    tbl[15] = mk(31, 1, BIG, 0, 0, 0, 0, 0, 0, 31, BIG, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, BIG, BIG, 0, 0, 0);

    // Reset, with a bypassable write presented to check nothing leaks.
    idle();
    rst = 1'b1;
    ra = {NR{5'd5}};
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    repeat (2) @(posedge clk);
    #1;
    rd0 = 5; we0 = 1; v0 = 64'h1234; iv = 1; ird = 5;
    #1;
    chk("reset val_b p0", val_b[XL-1:0], 64'd0);
    chk("reset val_n p0", val_n[XL-1:0], 64'd0);
    chk("reset hz_b", 64'(hz_b), 64'd0);
    chk("reset busy_b", 64'(busy_b), 64'd0);
    @(posedge clk);
    m_update();
    #1;
    rst = 1'b0;
    idle();

    // Directed table: all read ports address the same register.
    for (int t = 0; t < 17; t++) begin
      rd0 = tbl[t].rd0; we0 = tbl[t].we0; v0 = tbl[t].v0;
      rd1 = tbl[t].rd1; we1 = tbl[t].we1; v1 = tbl[t].v1;
      iv = tbl[t].iv; ird = tbl[t].ird; flush = tbl[t].fl;
      ra = {NR{tbl[t].ra}};
      #2;
      for (int k = 0; k < NR; k++) begin
        chk($sformatf("vec%0d val_b p%0d", t, k), val_b[XL*k +: XL], tbl[t].eb);
        chk($sformatf("vec%0d val_n p%0d", t, k), val_n[XL*k +: XL], tbl[t].en);
        chk($sformatf("vec%0d hz_b p%0d", t, k), 64'(hz_b[k]), 64'(tbl[t].hb));
        chk($sformatf("vec%0d hz_n p%0d", t, k), 64'(hz_n[k]), 64'(tbl[t].hn));
      end
      @(posedge clk);
      m_update();
      #1;
      chk($sformatf("vec%0d busy_b", t), 64'(busy_b), 64'(tbl[t].busy));
      chk($sformatf("vec%0d busy_n", t), 64'(busy_n), 64'(tbl[t].busy));
    end

    // Asynchronous reset mid-cycle after writing x5 with x5 pending.
    idle();
    rd0 = 5; we0 = 1; v0 = 64'hDEADBEEF; iv = 1; ird = 5; ra = {NR{5'd5}};
    run_cycle();
    idle();
    #1;
    chk("pre-rst x5", val_n[XL-1:0], 64'hDEADBEEF);
    chk("pre-rst busy5", 64'(busy_n[5]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async-rst x5 b", val_b[XL-1:0], 64'd0);
    chk("async-rst x5 n", val_n[XL-1:0], 64'd0);
    chk("async-rst busy", 64'(busy_b), 64'd0);
    chk("async-rst hz", 64'(hz_b), 64'd0);
    rd0 = 5; we0 = 1; v0 = 64'h77; iv = 1; ird = 5;
    @(posedge clk);
    m_update();
    #1;
    rst = 1'b0;
    idle();
    #1;
    chk("post-rst x5", val_n[XL-1:0], 64'd0);
    chk("post-rst busy", 64'(busy_n), 64'd0);
    #1;  // still before the next edge; run_cycle keeps to edge-relative timing
    @(posedge clk);
    m_update();
    #1;

    // Randomised traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      rst   = ($urandom_range(0, 299) == 0);
      rd0   = 5'($urandom_range(0, 31));
      rd1   = ($urandom_range(0, 3) == 0) ? rd0 : 5'($urandom_range(0, 31));
      we0   = $urandom_range(0, 1) == 1;
      we1   = $urandom_range(0, 1) == 1;
      v0    = {$urandom, $urandom};
      v1    = {$urandom, $urandom};
      iv    = $urandom_range(0, 1) == 1;
      ird   = ($urandom_range(0, 3) == 0) ? rd0 : 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NR; k++) begin
        case ($urandom_range(0, 3))
          0:       ra[5*k +: 5] = rd0;
          1:       ra[5*k +: 5] = rd1;
          default: ra[5*k +: 5] = 5'($urandom_range(0, 31));
        endcase
      end
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
